// File: rtl/flop_r_pkg.sv
// Shared datapath types and default widths for the flop_r register.
// The optional load enable is selected with FLOP_R_LOAD_EN.
package flop_r_pkg;

    localparam int FLOP_R_DEFAULT_W = 64;

    typedef logic [63:0] word_t;

endpackage

// File: rtl/flop_r.sv
// N-bit D register with synchronous active-high reset (PC and pipeline registers).
// Define FLOP_R_LOAD_EN to add the en port; otherwise d loads on every non-reset edge.
module flop_r
    import flop_r_pkg::*;
#(
    parameter int           N         = FLOP_R_DEFAULT_W,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
`ifdef FLOP_R_LOAD_EN
    input  logic         en,
`endif
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Reset outranks the load enable when it is compiled in.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
`ifdef FLOP_R_LOAD_EN
        end else if (en) begin
            q <= d;
`else
        end else begin
            q <= d;
`endif
        end
    end

endmodule

// File: tb/tb_flop_r.sv
// Scoreboard bench for flop_r at widths 64, 8 and 1; covers the en variant
// when FLOP_R_LOAD_EN is defined.
module tb_flop_r;
    import flop_r_pkg::*;

`ifdef FLOP_R_LOAD_EN
    localparam bit HasEn = 1'b1;
`else
    localparam bit HasEn = 1'b0;
`endif

    typedef struct {
        word_t      q64;
        logic [7:0] q8;
        logic       q1;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    word_t      d64 = '0;
    logic [7:0] d8 = '0;
    logic       d1 = 1'b0;
    word_t      q64;
    logic [7:0] q8;
    logic       q1;

    // Reference state: what each register should hold per the load/reset rules.
    word_t      m64;
    logic [7:0] m8;
    logic       m1;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    flop_r u_dut64 (
        .clk   (clk),
        .reset (reset),
`ifdef FLOP_R_LOAD_EN
        .en    (en),
`endif
        .d     (d64),
        .q     (q64)
    );

    flop_r #(.N(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk   (clk),
        .reset (reset),
`ifdef FLOP_R_LOAD_EN
        .en    (en),
`endif
        .d     (d8),
        .q     (q8)
    );

    flop_r #(.N(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
`ifdef FLOP_R_LOAD_EN
        .en    (en),
`endif
        .d     (d1),
        .q     (q1)
    );

    // Apply the spec's rules to the inputs present at the edge just taken.
    task automatic model_edge();
        exp_t e;
        if (reset) begin
            m64 = 64'h0;
            m8  = 8'hA5;
            m1  = 1'b0;
        end else if (!HasEn || en) begin
            m64 = d64;
            m8  = d8;
            m1  = d1;
        end
        e.q64 = m64;
        e.q8  = m8;
        e.q1  = m1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input word_t dv, input logic env);
        reset = rst;
        d64   = dv;
        d8    = dv[7:0];
        d1    = dv[0];
        en    = env;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: one expectation per edge, checked at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (q64 !== e.q64) begin
                    n_fail++;
                    $display("FAIL q64: got %h expected %h at %0t", q64, e.q64, $time);
                end
                n_tests++;
                if (q8 !== e.q8) begin
                    n_fail++;
                    $display("FAIL q8: got %h expected %h at %0t", q8, e.q8, $time);
                end
                n_tests++;
                if (q1 !== e.q1) begin
                    n_fail++;
                    $display("FAIL q1: got %b expected %b at %0t", q1, e.q1, $time);
                end
            end
        end
    end

    initial begin
        word_t r;
        m64 = 'x;
        m8  = 'x;
        m1  = 1'bx;

        // Reset with random data on d.
        for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'($urandom));

        // Plain loads, one new word per edge.
        for (int i = 0; i < 10; i++) step(1'b0, {$urandom, $urandom}, 1'b1);

        // Reset discards a stored all-ones value, release loads d at that edge.
        step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(1'b1, 64'h1234, 1'b1);
        step(1'b0, 64'h1234, 1'b1);

        // d toggles between edges; only the value at the edge is captured.
        d64 = 64'd5; d8 = 8'd5; d1 = 1'b1;
        #2;
        d64 = 64'd9; d8 = 8'd9; d1 = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Load-enable behaviour (en ignored in the default build).
        step(1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
        step(1'b0, 64'd7, 1'b0);
        step(1'b0, 64'd7, 1'b0);
        step(1'b0, 64'd7, 1'b1);
        step(1'b1, 64'd7, 1'b0);
        step(1'b0, 64'hDEAD, 1'b0);

        // Mixed random traffic with occasional reset.
        for (int i = 0; i < 40; i++) begin
            r = {$urandom, $urandom};
            step(($urandom_range(0, 7) == 0), r, 1'($urandom));
        end

        // Allow the monitor to drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
